// File: rtl/seq_pattern_detector.sv
// Programmable serial bit-pattern detector (Moore, registered match flag), with overlap/non-overlap modes.
// Optional saturating match counter built only when SEQDET_MATCH_COUNT_EN is defined; otherwise match_count is 0.
module seq_pattern_detector #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int CNT_W   = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               sequence_in,
  input  logic               in_valid,
  output logic               detector_out,
  output logic [LEN_W-1:0]   fill_level,
  output logic [CNT_W-1:0]   match_count
);

  // Handshake: in_valid qualifies sequence_in for one cycle; there is no
  // backpressure, and cfg_load on the same cycle wins and drops the sample.

  localparam logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(4'b1011);
  localparam logic [LEN_W-1:0]   RST_LEN = LEN_W'(4);
  localparam logic [LEN_W-1:0]   MAX_L   = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_det;

  logic [MAX_LEN-1:0] w_mask;
  logic [MAX_LEN-1:0] w_hist_next;
  logic [LEN_W-1:0]   w_fill_next;
  logic               w_sample;
  logic               w_match;
  logic [LEN_W-1:0]   w_len_clamped;

  always_comb begin
    w_len_clamped = cfg_len;
    if (cfg_len == '0) begin
      w_len_clamped = LEN_W'(1);
    end else if (cfg_len > MAX_L) begin
      w_len_clamped = MAX_L;
    end
  end

  // Only the low len_r bits of pattern and history take part in the compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
  end

  assign w_sample    = in_valid && !cfg_load;
  assign w_hist_next = {r_hist[MAX_LEN-2:0], sequence_in};
  assign w_fill_next = (r_fill < r_len) ? (r_fill + LEN_W'(1)) : r_len;
  assign w_match     = w_sample && (w_fill_next == r_len) &&
                       (((w_hist_next ^ r_pat) & w_mask) == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pat  <= RST_PAT;
      r_len  <= RST_LEN;
      r_ovl  <= 1'b1;
      r_hist <= '0;
      r_fill <= '0;
      r_det  <= 1'b0;
    end else if (cfg_load) begin
      r_pat  <= cfg_pattern;
      r_len  <= w_len_clamped;
      r_ovl  <= cfg_overlap;
      r_hist <= '0;
      r_fill <= '0;
      r_det  <= 1'b0;
    end else if (w_sample) begin
      r_det <= w_match;
      // Non-overlapping mode restarts from an empty history after each hit.
      if (w_match && !r_ovl) begin
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_hist_next;
        r_fill <= w_fill_next;
      end
    end else begin
      r_det <= 1'b0;
    end
  end

`ifdef SEQDET_MATCH_COUNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (cfg_load) begin
      r_cnt <= '0;
    end else if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign match_count = r_cnt;
`else
  assign match_count = '0;
`endif

  assign detector_out = r_det;
  assign fill_level   = r_fill;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench for seq_pattern_detector: a bit-queue reference model predicts
// detector_out, fill_level and match_count each cycle; a monitor compares them.
module tb_seq_pattern_detector;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;
  localparam int CNT_W   = 8;
  localparam int W       = 1 + LEN_W + CNT_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clock;
  logic               reset_n;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               sequence_in;
  logic               in_valid;
  logic               detector_out;
  logic [LEN_W-1:0]   fill_level;
  logic [CNT_W-1:0]   match_count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  // reference model state
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  bit                 m_ovl;
  bit                 m_q[$];
  int                 m_cnt;
  bit                 m_det;

  seq_pattern_detector #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .sequence_in (sequence_in),
    .in_valid    (in_valid),
    .detector_out(detector_out),
    .fill_level  (fill_level),
    .match_count (match_count)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int exp_count();
`ifdef SEQDET_MATCH_COUNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  function automatic int m_fill();
    return (m_q.size() < m_len) ? m_q.size() : m_len;
  endfunction

  task automatic model_reset();
    m_pat = MAX_LEN'(4'b1011);
    m_len = 4;
    m_ovl = 1'b1;
    m_q.delete();
    m_cnt = 0;
    m_det = 1'b0;
  endtask

  // Behavioural rule: a hit is when the last len sampled bits, oldest first,
  // spell pattern bits len-1 down to 0.
  task automatic model_step(input bit ld, input logic [MAX_LEN-1:0] pat, input int len,
                            input bit ovl, input bit v, input bit b);
    bit hit;
    int sz;
    if (ld) begin
      m_pat = pat;
      m_len = (len == 0) ? 1 : ((len > MAX_LEN) ? MAX_LEN : len);
      m_ovl = ovl;
      m_q.delete();
      m_det = 1'b0;
      m_cnt = 0;
    end else if (v) begin
      m_q.push_back(b);
      if (m_q.size() > 32) void'(m_q.pop_front());
      sz  = m_q.size();
      hit = (sz >= m_len);
      if (hit) begin
        for (int k = 0; k < m_len; k++) begin
          if (m_q[sz - m_len + k] != m_pat[m_len - 1 - k]) hit = 1'b0;
        end
      end
      m_det = hit;
      if (hit) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (!m_ovl) m_q.delete();
      end
    end else begin
      m_det = 1'b0;
    end
  endtask

  // driver: one cycle of stimulus, expected outputs pushed to the scoreboard
  task automatic drive(input bit ld, input logic [MAX_LEN-1:0] pat, input int len,
                       input bit ovl, input bit v, input bit b);
    cfg_load    = ld;
    cfg_pattern = ld ? pat : MAX_LEN'($urandom);
    cfg_len     = ld ? LEN_W'(len) : LEN_W'($urandom);
    cfg_overlap = ld ? ovl : 1'($urandom);
    in_valid    = v;
    sequence_in = b;
    model_step(ld, pat, len, ovl, v, b);
    exp_q.push_back({m_det, LEN_W'(m_fill()), CNT_W'(exp_count())});
    @(posedge clock);
    #2;
  endtask

  task automatic load(input logic [MAX_LEN-1:0] pat, input int len, input bit ovl);
    drive(1'b1, pat, len, ovl, 1'b0, 1'b0);
  endtask

  task automatic send(input bit b);
    drive(1'b0, '0, 0, 1'b0, 1'b1, b);
  endtask

  task automatic idle();
    drive(1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send(bits[i]);
  endtask

  // monitor: compares DUT outputs one time unit after each rising edge
  always @(posedge clock) begin
    logic [W-1:0] e;
    #1;
    if (reset_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("detector_out", int'(detector_out), int'(e[W-1]));
      check("fill_level", int'(fill_level), int'(e[CNT_W +: LEN_W]));
      check("match_count", int'(match_count), int'(e[CNT_W-1:0]));
    end
  end

  initial begin
    int budget;
    reset_n     = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    sequence_in = 1'b0;
    in_valid    = 1'b0;
    model_reset();
    #12;
    check("reset_det", int'(detector_out), 0);
    check("reset_fill", int'(fill_level), 0);
    check("reset_count", int'(match_count), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #2;

    // reset defaults, overlap: pulses after bits 4 and 7
    send_bits(32'b1011011, 7);
    // non-overlap reload of the same pattern
    load(8'b1011, 4, 1'b0);
    send_bits(32'b1011011, 7);
    // pattern 11, overlap: three consecutive pulses
    load(8'b11, 2, 1'b1);
    send_bits(32'b1111, 4);
    idle();
    // gaps keep history
    load(8'b1011, 4, 1'b1);
    send_bits(32'b10, 2);
    repeat (5) idle();
    send_bits(32'b11, 2);
    // load together with valid drops that bit
    send_bits(32'b101, 3);
    drive(1'b1, 8'b1011, 4, 1'b1, 1'b1, 1'b1);
    send(1'b1);
    // length clamps
    load(8'b0000_0001, 0, 1'b1);
    send_bits(32'b1101, 4);
    load(8'b1010_0110, MAX_LEN + 3, 1'b1);
    send_bits(32'b1010_0110_1010_0110, 16);
    // counter saturation with a one-bit pattern
    load(8'b1, 1, 1'b1);
    repeat (CNT_MAX + 10) send(1'b1);

    // asynchronous reset during a pulse
    load(8'b11, 2, 1'b1);
    send_bits(32'b11, 2);
    reset_n = 1'b0;
    #1;
    check("async_reset_det", int'(detector_out), 0);
    check("async_reset_fill", int'(fill_level), 0);
    check("async_reset_count", int'(match_count), 0);
    model_reset();
    cfg_load = 1'b0;
    in_valid = 1'b0;
    #2;
    reset_n = 1'b1;
    @(posedge clock);
    #2;
    send_bits(32'b1011, 4);

    // randomized traffic with occasional reloads
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        load(MAX_LEN'($urandom), int'($urandom_range(0, 15)), 1'($urandom));
      end else if ($urandom_range(0, 99) < 80) begin
        send(1'($urandom));
      end else begin
        idle();
      end
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clock);
      budget++;
    end
    #3;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
